// File: rtl/seq2_pkg.sv
// Shared definitions for the Seq2 sequencer and its fetch/program-load stage.
// The instruction and address widths are fixed by the sequencer's instruction format.
package seq2_pkg;

  localparam int SEQ2_INST_W = 20;
  localparam int SEQ2_ADDR_W = 8;
  localparam int SEQ2_DEPTH  = 1 << SEQ2_ADDR_W;

  typedef enum logic [1:0] {
    SEQ2F_IDLE  = 2'd0,
    SEQ2F_COUNT = 2'd1,
    SEQ2F_DATA  = 2'd2,
    SEQ2F_RUN   = 2'd3
  } seq2f_state_e;

  // Only the low nibble of the first byte carries instruction bits.
  function automatic logic [SEQ2_INST_W-1:0] seq2_pack_word(
    input logic [3:0] hi,
    input logic [7:0] mid,
    input logic [7:0] lo
  );
    return {hi, mid, lo};
  endfunction

endpackage

// File: rtl/seq2_fetch_if.sv
// Load-stream and fetch signals between the fetch stage and its neighbours.
// The master drives bytes and the fetch address; the slave (seq2_fetch) answers.
interface seq2_fetch_if;
  import seq2_pkg::*;

  logic                   load_begin;
  logic [7:0]             load_data;
  logic                   load_valid;
  logic                   load_ready;
  logic [SEQ2_ADDR_W-1:0] next;
  logic [SEQ2_INST_W-1:0] inst;
  logic                   inst_en;
  logic                   seq_reset;
  logic                   loaded;

  modport master (
    output load_begin, load_data, load_valid, next,
    input  load_ready, inst, inst_en, seq_reset, loaded
  );

  modport slave (
    input  load_begin, load_data, load_valid, next,
    output load_ready, inst, inst_en, seq_reset, loaded
  );

endinterface

// File: rtl/seq2_prog_ram.sv
// 256 x 20 single-port synchronous program RAM, one-cycle read latency.
// A write returns the written word on rdata (write-first).
module seq2_prog_ram
  import seq2_pkg::*;
(
  input  logic                   clock,
  input  logic                   we,
  input  logic [SEQ2_ADDR_W-1:0] addr,
  input  logic [SEQ2_INST_W-1:0] wdata,
  output logic [SEQ2_INST_W-1:0] rdata
);

  logic [SEQ2_INST_W-1:0] mem [SEQ2_DEPTH];

  // NOTE: the array and its read register have no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/seq2_fetch.sv
// Program-load and instruction-fetch stage in front of the Seq2 sequencer.
// Loads the RAM from a byte stream, then serves inst/inst_en at the sequencer's next address.
module seq2_fetch
  import seq2_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  seq2_fetch_if.slave  bus
);

  seq2f_state_e state, state_nxt;

  logic [SEQ2_ADDR_W-1:0] word_cnt;
  logic [SEQ2_ADDR_W-1:0] word_addr;
  logic [1:0]             byte_idx;
  logic [3:0]             byte0_q;
  logic [7:0]             byte1_q;
  logic                   loaded_q;
  logic [SEQ2_ADDR_W-1:0] r_addr;
  logic                   r_valid;

  logic                   accept;
  logic                   word_done;
  logic                   last_word;
  logic                   ram_we;
  logic [SEQ2_ADDR_W-1:0] ram_addr;
  logic [SEQ2_INST_W-1:0] ram_wdata;
  logic [SEQ2_INST_W-1:0] ram_rdata;

  // A count of 0 wraps to 255 here, which is how 0 comes to mean 256 words.
  assign last_word = (word_addr == word_cnt - 8'd1);
  assign accept    = bus.load_valid && bus.load_ready;
  assign word_done = accept && (state == SEQ2F_DATA) && (byte_idx == 2'd2);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SEQ2F_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    bus.load_ready = 1'b0;
    bus.seq_reset  = 1'b1;
    unique case (state)
      SEQ2F_IDLE: begin
        if (bus.load_begin) state_nxt = SEQ2F_COUNT;
      end
      SEQ2F_COUNT: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) state_nxt = SEQ2F_DATA;
      end
      SEQ2F_DATA: begin
        bus.load_ready = 1'b1;
        if (word_done && last_word) state_nxt = SEQ2F_RUN;
      end
      SEQ2F_RUN: begin
        bus.seq_reset = 1'b0;
        if (bus.load_begin) state_nxt = SEQ2F_COUNT;
      end
      default: state_nxt = SEQ2F_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt  <= '0;
      word_addr <= '0;
      byte_idx  <= '0;
      byte0_q   <= '0;
      byte1_q   <= '0;
      loaded_q  <= 1'b0;
      r_addr    <= '0;
      r_valid   <= 1'b0;
    end else begin
      // The match register only tracks addresses while staying in Run.
      r_valid <= (state == SEQ2F_RUN) && (state_nxt == SEQ2F_RUN);
      if (state == SEQ2F_RUN) r_addr <= bus.next;

      if (state_nxt == SEQ2F_COUNT) begin
        loaded_q <= 1'b0;
      end else if (word_done && last_word) begin
        loaded_q <= 1'b1;
      end

      if (accept && (state == SEQ2F_COUNT)) begin
        word_cnt  <= bus.load_data;
        word_addr <= '0;
        byte_idx  <= '0;
      end else if (accept && (state == SEQ2F_DATA)) begin
        unique case (byte_idx)
          2'd0: begin
            byte0_q  <= bus.load_data[3:0];
            byte_idx <= 2'd1;
          end
          2'd1: begin
            byte1_q  <= bus.load_data;
            byte_idx <= 2'd2;
          end
          default: begin
            byte_idx  <= 2'd0;
            word_addr <= word_addr + 8'd1;
          end
        endcase
      end
    end
  end

  // The write port borrows the address only while a program is streaming in.
  assign ram_we    = word_done;
  assign ram_addr  = (state == SEQ2F_DATA) ? word_addr : bus.next;
  assign ram_wdata = seq2_pack_word(byte0_q, byte1_q, bus.load_data);

  seq2_prog_ram u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.inst    = (state == SEQ2F_RUN) ? ram_rdata : '0;
  assign bus.inst_en = r_valid && (r_addr == bus.next);
  assign bus.loaded  = loaded_q;

endmodule

// File: tb/tb_seq2_fetch.sv
// Directed bench for seq2_fetch: expected words are queued as programs are streamed in
// and compared when the fetch port later returns them.
module tb_seq2_fetch;

  typedef struct {
    logic [7:0]  addr;
    logic [19:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  seq2_fetch_if bus ();

  seq2_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.load_data  = b;
    bus.load_valid = 1'b1;
    while (!bus.load_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("load_ready_timeout", 32'(bus.load_ready), 32'd1);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_begin();
    bus.load_begin = 1'b1;
    tick();
    bus.load_begin = 1'b0;
  endtask

  task automatic fetch_check(input logic [7:0] addr, input logic [19:0] exp);
    int n;
    n = 0;
    bus.next = addr;
    #1;
    while (!bus.inst_en && n < 8) begin
      tick();
      n++;
    end
    check($sformatf("fetch_en[%0d]", addr), 32'(bus.inst_en), 32'd1);
    check($sformatf("fetch_inst[%0d]", addr), 32'(bus.inst), 32'(exp));
  endtask

  task automatic drain_scoreboard();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      fetch_check(e.addr, e.data);
    end
  endtask

  initial begin
    exp_t e;
    bus.load_begin = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_valid = 1'b0;
    bus.next       = 8'h00;

    // Reset held for two cycles.
    tick();
    tick();
    check("rst_inst_en",    32'(bus.inst_en),    32'd0);
    check("rst_seq_reset",  32'(bus.seq_reset),  32'd1);
    check("rst_loaded",     32'(bus.loaded),     32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_inst",       32'(bus.inst),       32'd0);
    reset = 1'b0;
    tick();
    check("idle_load_ready", 32'(bus.load_ready), 32'd0);

    // Two-word program.
    pulse_begin();
    check("count_load_ready", 32'(bus.load_ready), 32'd1);
    send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h30); send_byte(8'h5A);
    exp_q.push_back('{addr: 8'd0, data: 20'h1305A});
    send_byte(8'h03); send_byte(8'h07);
    exp_q.push_back('{addr: 8'd1, data: 20'h30700});
    bus.load_data  = 8'h00;
    bus.load_valid = 1'b1;
    #1;
    check("pre_run_seq_reset", 32'(bus.seq_reset), 32'd1);
    check("pre_run_loaded",    32'(bus.loaded),    32'd0);
    tick();
    bus.load_valid = 1'b0;
    check("run1_loaded",     32'(bus.loaded),     32'd1);
    check("run1_seq_reset",  32'(bus.seq_reset),  32'd0);
    check("run1_inst_en",    32'(bus.inst_en),    32'd0);
    check("run1_load_ready", 32'(bus.load_ready), 32'd0);

    // Fetch timing with next held at 0, then stepped to 1.
    tick();
    e = exp_q.pop_front();
    check("run2_inst_en", 32'(bus.inst_en), 32'd1);
    check("run2_inst",    32'(bus.inst),    32'(e.data));
    tick();
    check("hold_inst_en", 32'(bus.inst_en), 32'd1);
    bus.next = 8'd1;
    #1;
    check("step_gap_inst_en", 32'(bus.inst_en), 32'd0);
    tick();
    e = exp_q.pop_front();
    check("step_inst_en", 32'(bus.inst_en), 32'd1);
    check("step_inst",    32'(bus.inst),    32'(e.data));

    // Reload from Run with a byte offered on the same edge: not consumed in Run.
    bus.load_begin = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h05;
    tick();
    bus.load_begin = 1'b0;
    bus.load_valid = 1'b0;
    check("reload_seq_reset",  32'(bus.seq_reset),  32'd1);
    check("reload_inst_en",    32'(bus.inst_en),    32'd0);
    check("reload_loaded",     32'(bus.loaded),     32'd0);
    check("reload_load_ready", 32'(bus.load_ready), 32'd1);

    // Full 256-word load, word k = k, bytes back to back.
    send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'(k));
      exp_q.push_back('{addr: 8'(k), data: 20'(k)});
      if (k == 254) check("full_no_early_run", 32'(bus.seq_reset), 32'd1);
    end
    check("full_loaded",    32'(bus.loaded),    32'd1);
    check("full_seq_reset", 32'(bus.seq_reset), 32'd0);
    drain_scoreboard();

    // Reset after byte 1 of word 1.
    pulse_begin();
    send_byte(8'h02);
    send_byte(8'h0F); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h01); send_byte(8'h22);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("midrst_loaded",     32'(bus.loaded),     32'd0);
    check("midrst_seq_reset",  32'(bus.seq_reset),  32'd1);
    check("midrst_load_ready", 32'(bus.load_ready), 32'd0);
    check("midrst_inst_en",    32'(bus.inst_en),    32'd0);
    tick();
    pulse_begin();
    send_byte(8'h01);
    send_byte(8'h04); send_byte(8'h56); send_byte(8'h78);
    check("fresh_loaded", 32'(bus.loaded), 32'd1);
    exp_q.push_back('{addr: 8'd0, data: 20'h45678});
    exp_q.push_back('{addr: 8'd1, data: 20'h00001});
    drain_scoreboard();

    // Reload with 3-cycle valid gaps and a load_begin ignored during Data.
    pulse_begin();
    send_byte(8'h03);
    repeat (3) tick();
    send_byte(8'hF3); repeat (3) tick();
    send_byte(8'h12);
    bus.load_begin = 1'b1;
    tick();
    bus.load_begin = 1'b0;
    repeat (2) tick();
    send_byte(8'h34); repeat (3) tick();
    exp_q.push_back('{addr: 8'd0, data: 20'h31234});
    send_byte(8'hA5); repeat (3) tick();
    send_byte(8'h00); repeat (3) tick();
    send_byte(8'hFF); repeat (3) tick();
    exp_q.push_back('{addr: 8'd1, data: 20'h500FF});
    send_byte(8'h00); repeat (3) tick();
    send_byte(8'h80); repeat (3) tick();
    check("gap_not_done_early", 32'(bus.loaded), 32'd0);
    send_byte(8'h01);
    exp_q.push_back('{addr: 8'd2, data: 20'h08001});
    check("gap_loaded", 32'(bus.loaded), 32'd1);
    drain_scoreboard();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
